fc_cpu_bus_capture: RTL and testbench

Front end of the cartridge CPLD: samples the asynchronous Famicom CPU bus (M2, /ROMSEL, R/W, A14..A0, D7..D0) in the osc50 domain and produces clean single-cycle write and cycle strobes with latched address and data. It sits directly upstream of the mapper register logic, such as the mapper 94 PRG bank register, which then updates on `wr_stb & wr_rom` in osc50 instead of clocking on the raw M2 edge. It also rejects M2 glitches and flags short or stalled M2 cycles.

---
 rtl/fc_bus_pkg.sv | 18 +
 rtl/fc_sync_filter.sv | 52 +++++
 rtl/fc_cpu_bus_capture.sv | 113 +++++++++++
 tb/tb_fc_cpu_bus_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_bus_pkg.sv
// Shared types and constants for the Famicom CPU bus front end and the mapper logic behind it.
package fc_bus_pkg;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_HIGH  = 2'd1,
        S_CAPT  = 2'd2,
        S_STALL = 2'd3
    } cap_state_t;

    localparam int unsigned M2_FILT_DEF   = 3;
    localparam int unsigned CAP_DELAY_DEF = 8;
    localparam int unsigned TIMEOUT_DEF   = 255;

    localparam int unsigned CPU_A_W = 15;
    localparam int unsigned CPU_D_W = 8;

endpackage

// File: rtl/fc_sync_filter.sv
// Two-flop synchronizer followed by an optional run-length glitch filter (FILT == 0 bypasses it).
module fc_sync_filter #(
    parameter int unsigned FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    generate
        if (FILT == 0) begin : g_bypass
            assign q = s2;
        end else begin : g_filter
            logic       qf;
            logic [2:0] run;

            // The output flips only on the FILT-th consecutive disagreeing sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    qf  <= 1'b0;
                    run <= 3'd0;
                end else if (s2 != qf) begin
                    if (run == 3'(FILT - 1)) begin
                        qf  <= s2;
                        run <= 3'd0;
                    end else begin
                        run <= run + 3'd1;
                    end
                end else begin
                    run <= 3'd0;
                end
            end

            assign q = qf;
        end
    endgenerate

endmodule

// File: rtl/fc_cpu_bus_capture.sv
// Samples the asynchronous CPU bus in the osc50 domain and emits single-cycle write/cycle strobes.
module fc_cpu_bus_capture
    import fc_bus_pkg::*;
#(
    parameter int unsigned M2_FILT   = M2_FILT_DEF,
    parameter int unsigned CAP_DELAY = CAP_DELAY_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic               osc50,
    input  logic               m2_rst,
    input  logic               m2,
    input  logic               romsel,
    input  logic               cpu_rw_in,
    input  logic [CPU_A_W-1:0] cpu_addr_in,
    input  logic [CPU_D_W-1:0] cpu_data,
    output logic               wr_stb,
    output logic               wr_rom,
    output logic [CPU_A_W-1:0] wr_addr,
    output logic [CPU_D_W-1:0] wr_data,
    output logic               cyc_stb,
    output logic               short_err,
    output logic               bus_stall
);

    logic       m2f;
    logic       romsel_s;
    logic       rw_s;
    logic       cap_romsel;
    logic       cap_rw;
    logic [7:0] cnt;
    cap_state_t state;

    fc_sync_filter #(.FILT(M2_FILT)) u_m2_sync (
        .clk(osc50), .rst_n(m2_rst), .d(m2), .q(m2f)
    );

    fc_sync_filter #(.FILT(0)) u_romsel_sync (
        .clk(osc50), .rst_n(m2_rst), .d(romsel), .q(romsel_s)
    );

    fc_sync_filter #(.FILT(0)) u_rw_sync (
        .clk(osc50), .rst_n(m2_rst), .d(cpu_rw_in), .q(rw_s)
    );

    // Strobes are valid-only: wr_stb/cyc_stb are one-cycle pulses with no ready,
    // and wr_addr/wr_data/wr_rom are stable for the whole cycle wr_stb is high.
    always_ff @(posedge osc50 or negedge m2_rst) begin
        if (!m2_rst) begin
            state      <= S_LOW;
            cnt        <= 8'd0;
            cap_romsel <= 1'b0;
            cap_rw     <= 1'b0;
            wr_stb     <= 1'b0;
            wr_rom     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cyc_stb    <= 1'b0;
            short_err  <= 1'b0;
            bus_stall  <= 1'b0;
        end else begin
            wr_stb    <= 1'b0;
            cyc_stb   <= 1'b0;
            short_err <= 1'b0;
            case (state)
                S_LOW: begin
                    if (m2f) begin
                        cnt   <= 8'd0;
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (!m2f) begin
                        short_err <= 1'b1;
                        state     <= S_LOW;
                    end else if (cnt == 8'(CAP_DELAY - 1)) begin
                        // Address and data come straight from the pins: they are stable by now.
                        wr_addr    <= cpu_addr_in;
                        wr_data    <= cpu_data;
                        cap_romsel <= romsel_s;
                        cap_rw     <= rw_s;
                        cnt        <= 8'd0;
                        state      <= S_CAPT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_CAPT: begin
                    if (!m2f) begin
                        cyc_stb <= 1'b1;
                        if (!cap_rw) begin
                            wr_stb <= 1'b1;
                            wr_rom <= ~cap_romsel;
                        end
                        state <= S_LOW;
                    end else if (cnt == 8'(TIMEOUT)) begin
                        bus_stall <= 1'b1;
                        state     <= S_STALL;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_STALL: begin
                    if (!m2f) begin
                        bus_stall <= 1'b0;
                        state     <= S_LOW;
                    end
                end
                default: state <= S_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_cpu_bus_capture.sv
// Bench for fc_cpu_bus_capture: drives timed CPU bus cycles and checks strobes against a transaction model.
`timescale 1ns/1ps
module tb_fc_cpu_bus_capture;

    logic        osc50 = 1'b0;
    logic        m2_rst = 1'b1;
    logic        m2 = 1'b0;
    logic        romsel = 1'b1;
    logic        cpu_rw_in = 1'b1;
    logic [14:0] cpu_addr_in = '0;
    logic [7:0]  cpu_data = '0;
    logic        wr_stb, wr_rom, cyc_stb, short_err, bus_stall;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;

    fc_cpu_bus_capture dut (
        .osc50(osc50), .m2_rst(m2_rst), .m2(m2), .romsel(romsel),
        .cpu_rw_in(cpu_rw_in), .cpu_addr_in(cpu_addr_in), .cpu_data(cpu_data),
        .wr_stb(wr_stb), .wr_rom(wr_rom), .wr_addr(wr_addr), .wr_data(wr_data),
        .cyc_stb(cyc_stb), .short_err(short_err), .bus_stall(bus_stall)
    );

    // clock / reset
    always #10 osc50 = ~osc50;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int short_cnt = 0;
    int lone_wr = 0;
    int exp_cyc = 0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    // monitor: record every strobe, sampled away from the active edge
    always @(negedge osc50) begin
        if (m2_rst) begin
            if (wr_stb) obs_q.push_back({wr_rom, wr_addr, wr_data});
            if (cyc_stb) cyc_cnt++;
            if (short_err) short_cnt++;
            if (wr_stb && !cyc_stb) lone_wr++;
        end
    end

    // driver + transaction model: a full-length cycle completes once; a write reports {rom, A14..A0, D}
    task automatic cpu_cycle(input logic rw, input logic [15:0] a, input logic [7:0] d,
                             input int hi_ns, input int lo_ns);
        cpu_rw_in   = rw;
        romsel      = ~a[15];
        cpu_addr_in = a[14:0];
        cpu_data    = rw ? 8'($urandom) : d;
        m2 = 1'b0;
        #(lo_ns);
        m2 = 1'b1;
        #(hi_ns);
        m2 = 1'b0;
        exp_cyc++;
        if (!rw) exp_q.push_back({a[15], a[14:0], d});
    endtask

    task automatic test_reset();
        #3 m2_rst = 1'b0;
        #20;
        total++;
        if ({wr_stb, wr_rom, wr_addr, wr_data, cyc_stb, short_err, bus_stall} !== 28'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {wr_stb, wr_rom, wr_addr, wr_data, cyc_stb, short_err, bus_stall});
        end
        @(posedge osc50); #7 m2_rst = 1'b1;
        #200;
        total++;
        if ({wr_stb, cyc_stb, short_err, bus_stall} !== 4'd0 || cyc_cnt != 0) begin
            bad++;
            $display("FAIL reset_idle: strobes %b cycles %0d required 0", {wr_stb, cyc_stb, short_err, bus_stall}, cyc_cnt);
        end
    endtask

    task automatic test_rom_write();
        logic [23:0] e, o;
        cpu_cycle(1'b0, 16'h8000, 8'h1C, 350, 209);
        #400;
        total++;
        if (cyc_cnt != exp_cyc) begin
            bad++; $display("FAIL rom_write_cyc: got %0d required %0d", cyc_cnt, exp_cyc);
        end
        e = exp_q.pop_front();
        total++;
        if (obs_q.size() != 1) begin
            bad++; $display("FAIL rom_write_count: got %0d writes required 1", obs_q.size());
            obs_q.delete();
        end else begin
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL rom_write_data: got %h required %h", o, e); end
        end
        total++;
        if (lone_wr != 0) begin bad++; $display("FAIL rom_write_same_cycle: lone wr_stb %0d required 0", lone_wr); end
    endtask

    task automatic test_read();
        logic [15:0] a = 16'hC123;
        cpu_cycle(1'b1, a, 8'h00, 350, 209);
        #400;
        total++;
        if (cyc_cnt != exp_cyc) begin bad++; $display("FAIL read_cyc: got %0d required %0d", cyc_cnt, exp_cyc); end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL read_no_write: got %0d writes required 0", obs_q.size()); obs_q.delete();
        end
        total++;
        if (wr_addr !== a[14:0]) begin bad++; $display("FAIL read_addr: got %h required %h", wr_addr, a[14:0]); end
    endtask

    task automatic test_prg_ram_write();
        logic [23:0] e, o;
        cpu_cycle(1'b0, 16'h6000, 8'hA5, 350, 209);
        #400;
        e = exp_q.pop_front();
        total++;
        if (obs_q.size() != 1) begin
            bad++; $display("FAIL ram_write_count: got %0d writes required 1", obs_q.size()); obs_q.delete();
        end else begin
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL ram_write_data: got %h required %h", o, e); end
        end
        total++;
        if (wr_rom !== 1'b0) begin bad++; $display("FAIL ram_write_rom: got %b required 0", wr_rom); end
    endtask

    task automatic test_glitch();
        logic [23:0] o;
        int s0 = short_cnt;
        int c0 = cyc_cnt;
        // high glitch of two osc50 samples while the bus is idle
        @(posedge osc50); #7 m2 = 1'b1; #40 m2 = 1'b0;
        #300;
        total++;
        if (cyc_cnt != c0 || short_cnt != s0 || obs_q.size() != 0) begin
            bad++; $display("FAIL glitch_high: cyc %0d short %0d writes %0d required %0d %0d 0",
                            cyc_cnt, short_cnt, obs_q.size(), c0, s0);
        end
        // write with a brief low drop inside the high phase
        cpu_rw_in = 1'b0; romsel = 1'b0; cpu_addr_in = 15'h0ABC; cpu_data = 8'h5A;
        #209 m2 = 1'b1;
        #200;
        @(posedge osc50); #7 m2 = 1'b0; #40 m2 = 1'b1;
        #200 m2 = 1'b0;
        #400;
        total++;
        if (cyc_cnt != c0 + 1 || short_cnt != s0) begin
            bad++; $display("FAIL glitch_low_cyc: cyc %0d short %0d required %0d %0d", cyc_cnt, short_cnt, c0 + 1, s0);
        end
        exp_cyc = cyc_cnt;
        total++;
        if (obs_q.size() != 1) begin
            bad++; $display("FAIL glitch_low_count: got %0d writes required 1", obs_q.size()); obs_q.delete();
        end else begin
            o = obs_q.pop_front();
            total++;
            if (o !== {1'b1, 15'h0ABC, 8'h5A}) begin
                bad++; $display("FAIL glitch_low_data: got %h required %h", o, {1'b1, 15'h0ABC, 8'h5A});
            end
        end
    endtask

    task automatic test_short();
        int s0 = short_cnt;
        int c0 = cyc_cnt;
        cpu_rw_in = 1'b0; romsel = 1'b0; cpu_addr_in = 15'h1234; cpu_data = 8'h77;
        #209;
        @(posedge osc50); #7 m2 = 1'b1; #120 m2 = 1'b0;
        #400;
        total++;
        if (short_cnt != s0 + 1) begin bad++; $display("FAIL short_err: got %0d pulses required %0d", short_cnt - s0, 1); end
        total++;
        if (cyc_cnt != c0 || obs_q.size() != 0) begin
            bad++; $display("FAIL short_no_strobe: cyc %0d writes %0d required %0d 0", cyc_cnt, obs_q.size(), c0);
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] e, o;
        for (int i = 0; i < 24; i++) begin
            cpu_cycle(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                      $urandom_range(320, 380), $urandom_range(200, 260));
        end
        #400;
        total++;
        if (cyc_cnt != exp_cyc) begin bad++; $display("FAIL b2b_cyc: got %0d required %0d", cyc_cnt, exp_cyc); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL b2b_missing: required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL b2b_write: got %h required %h", o, e); end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL b2b_extra: %0d extra writes", obs_q.size()); obs_q.delete(); end
        total++;
        if (lone_wr != 0) begin bad++; $display("FAIL b2b_same_cycle: lone wr_stb %0d required 0", lone_wr); end
    endtask

    task automatic test_stall();
        int c0 = cyc_cnt;
        cpu_rw_in = 1'b0; romsel = 1'b0; cpu_addr_in = 15'h2222; cpu_data = 8'h33;
        #209 m2 = 1'b1;
        #5000;
        total++;
        if (bus_stall !== 1'b0) begin bad++; $display("FAIL stall_early: got %b required 0", bus_stall); end
        #800;
        total++;
        if (bus_stall !== 1'b1) begin bad++; $display("FAIL stall_set: got %b required 1", bus_stall); end
        #200 m2 = 1'b0;
        #400;
        total++;
        if (bus_stall !== 1'b0) begin bad++; $display("FAIL stall_clear: got %b required 0", bus_stall); end
        total++;
        if (cyc_cnt != c0 || obs_q.size() != 0) begin
            bad++; $display("FAIL stall_no_strobe: cyc %0d writes %0d required %0d 0", cyc_cnt, obs_q.size(), c0);
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_capt();
        logic [23:0] e, o;
        int c0 = cyc_cnt;
        cpu_rw_in = 1'b0; romsel = 1'b0; cpu_addr_in = 15'h7F0F; cpu_data = 8'hC3;
        #209 m2 = 1'b1;
        #400;
        @(posedge osc50); #7 m2_rst = 1'b0;
        #1;
        total++;
        if ({wr_stb, wr_rom, wr_addr, wr_data, cyc_stb, short_err, bus_stall} !== 28'd0) begin
            bad++; $display("FAIL reset_mid_capt: got %h required 0",
                            {wr_stb, wr_rom, wr_addr, wr_data, cyc_stb, short_err, bus_stall});
        end
        #100 m2 = 1'b0;
        #100 m2_rst = 1'b1;
        #300;
        total++;
        if (cyc_cnt != c0 || obs_q.size() != 0) begin
            bad++; $display("FAIL reset_discard: cyc %0d writes %0d required %0d 0", cyc_cnt, obs_q.size(), c0);
            obs_q.delete();
        end
        exp_cyc = cyc_cnt;
        cpu_cycle(1'b0, 16'hE001, 8'h96, 350, 209);
        #400;
        e = exp_q.pop_front();
        total++;
        if (obs_q.size() != 1) begin
            bad++; $display("FAIL post_reset_count: got %0d writes required 1", obs_q.size()); obs_q.delete();
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL post_reset_write: got %h required %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_rom_write();
        test_read();
        test_prg_ram_write();
        test_glitch();
        test_short();
        test_back_to_back();
        test_stall();
        test_reset_mid_capt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
